// File: rtl/memory_access_stage.sv
// RV32I memory stage: formats stores and extends loads on a handshaked data port.
// It stalls while an access is outstanding and holds the M->W pipeline register.
module memory_access_stage #(
    parameter int DATA_WIDTH             = 32,
    parameter int REG_FILE_ADDRESS_WIDTH = 5,
    parameter int TIMEOUT_CYCLES         = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              RegWriteM,
    input  logic [1:0]                        ResultSrcM,
    input  logic                              MemWriteM,
    input  logic [DATA_WIDTH-1:0]             ALUResultM,
    input  logic [DATA_WIDTH-1:0]             WriteDataM,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM,
    input  logic [DATA_WIDTH-1:0]             PCPlus4M,
    input  logic [2:0]                        AddressingControlM,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [DATA_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic [3:0]                        mem_be,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    input  logic                              mem_ack,
    output logic                              StallM,
    output logic                              RegWriteW,
    output logic [1:0]                        ResultSrcW,
    output logic [DATA_WIDTH-1:0]             ALUResultW,
    output logic [DATA_WIDTH-1:0]             ReadDataW,
    output logic [REG_FILE_ADDRESS_WIDTH-1:0] RdW,
    output logic [DATA_WIDTH-1:0]             PCPlus4W,
    output logic                              MemFaultW
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic       is_load;
    logic       access;
    logic [1:0] off;
    logic       illegal;
    logic       misaligned;
    logic       fault;
    logic       timeout;
    logic [DATA_WIDTH-1:0] load_data;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] o);
        case (f3)
            3'b000:  store_be = 4'b0001 << o;
            3'b001:  store_be = 4'b0011 << o;
            3'b010:  store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'b000:  store_data = {4{wd[7:0]}};
            3'b001:  store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] o,
                                                input logic [31:0] rd);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        case (o)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = o[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b100:  load_extend = {24'd0, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = rd;
        endcase
    endfunction

    always_comb begin
        is_load    = (ResultSrcM == 2'b01);
        access     = MemWriteM | is_load;
        off        = ALUResultM[1:0];
        illegal    = !(AddressingControlM inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                     (AddressingControlM[2] && MemWriteM);
        misaligned = (AddressingControlM[1:0] == 2'b01 && off[0]) ||
                     (AddressingControlM == 3'b010 && off != 2'b00);
        fault      = access & (illegal | misaligned);
        // Reset drops the request at once, even with an access still on the inputs.
        mem_req    = access & ~fault & ~rst;
        timeout    = (state == S_WAIT) & ~mem_ack & (cnt == CNT_LAST);
        StallM     = mem_req & ~mem_ack & ~timeout;
        mem_we     = MemWriteM;
        mem_addr   = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
        mem_wdata  = store_data(AddressingControlM, WriteDataM);
        mem_be     = (MemWriteM && !fault) ? store_be(AddressingControlM, off) : 4'b0000;
        load_data  = load_extend(AddressingControlM, off, mem_rdata);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_req && !mem_ack) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (mem_ack || timeout) state <= S_IDLE;
                    else                    cnt   <= cnt + 1'b1;
                end
            endcase
        end
    end

    // M->W register: bubbles during stalls, fault flag on bad access or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
            MemFaultW  <= 1'b0;
        end else if (StallM) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
            MemFaultW  <= 1'b0;
        end else begin
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            if (fault || timeout) begin
                RegWriteW <= 1'b0;
                ReadDataW <= '0;
                MemFaultW <= 1'b1;
            end else begin
                RegWriteW <= RegWriteM;
                ReadDataW <= (mem_req && mem_ack) ? load_data : '0;
                MemFaultW <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: loads, stores, wait states, faults, timeout, reset.
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic [2:0]  AddressingControlM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W;
    logic        MemFaultW;

    int errors = 0;
    int checks = 0;

    memory_access_stage #(
        .DATA_WIDTH(32), .REG_FILE_ADDRESS_WIDTH(5), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .PCPlus4M(PCPlus4M), .AddressingControlM(AddressingControlM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W), .MemFaultW(MemFaultW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present an instruction on the M inputs half a cycle before the capturing edge.
    task automatic put(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [2:0] f3);
        @(negedge clk);
        RegWriteM          = rw;
        ResultSrcM         = rs;
        MemWriteM          = mw;
        ALUResultM         = alu;
        WriteDataM         = wd;
        RdM                = rd;
        PCPlus4M           = alu + 32'h1000;
        AddressingControlM = f3;
        #1;
    endtask

    task automatic edge_w();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ext(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] exp);
        mem_rdata = 32'h80FF7F01;
        mem_ack   = 1'b1;
        put(1'b1, 2'b01, 1'b0, addr, 32'h0, 5'd7, f3);
        chk({tag, "_stall"}, {31'd0, StallM}, 32'd0);
        edge_w();
        chk(tag, ReadDataW, exp);
    endtask

    initial begin
        rst = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0;
        ALUResultM = 32'h100; WriteDataM = 32'h0; RdM = 5'd3;
        PCPlus4M = 32'h4; AddressingControlM = 3'b010;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall", {31'd0, StallM}, 32'd0);
        chk("rst_regwrite", {31'd0, RegWriteW}, 32'd0);
        chk("rst_readdata", ReadDataW, 32'd0);
        chk("rst_alures", ALUResultW, 32'd0);
        chk("rst_fault", {31'd0, MemFaultW}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait LW
        mem_rdata = 32'hDEADBEEF;
        mem_ack   = 1'b1;
        put(1'b1, 2'b01, 1'b0, 32'h100, 32'h0, 5'd5, 3'b010);
        chk("lw_req", {31'd0, mem_req}, 32'd1);
        chk("lw_stall", {31'd0, StallM}, 32'd0);
        chk("lw_be", {28'd0, mem_be}, 32'd0);
        chk("lw_addr", mem_addr, 32'h100);
        edge_w();
        chk("lw_data", ReadDataW, 32'hDEADBEEF);
        chk("lw_regwrite", {31'd0, RegWriteW}, 32'd1);
        chk("lw_rd", {27'd0, RdW}, 32'd5);
        chk("lw_fault", {31'd0, MemFaultW}, 32'd0);

        load_ext("lb_off3", 32'h103, 3'b000, 32'hFFFFFF80);
        load_ext("lbu_off3", 32'h103, 3'b100, 32'h00000080);
        load_ext("lh_off2", 32'h102, 3'b001, 32'hFFFF80FF);
        load_ext("lhu_off0", 32'h100, 3'b101, 32'h00007F01);

        // Stores
        put(1'b0, 2'b00, 1'b1, 32'h203, 32'h123456AB, 5'd0, 3'b000);
        chk("sb_be", {28'd0, mem_be}, 32'b1000);
        chk("sb_wdata", mem_wdata, 32'hABABABAB);
        chk("sb_addr", mem_addr, 32'h200);
        chk("sb_we", {31'd0, mem_we}, 32'd1);
        chk("sb_req", {31'd0, mem_req}, 32'd1);
        put(1'b0, 2'b00, 1'b1, 32'h202, 32'h123456AB, 5'd0, 3'b001);
        chk("sh_be", {28'd0, mem_be}, 32'b1100);
        chk("sh_wdata", mem_wdata, 32'h56AB56AB);
        put(1'b0, 2'b00, 1'b1, 32'h204, 32'h11223344, 5'd0, 3'b010);
        chk("sw_be", {28'd0, mem_be}, 32'b1111);
        chk("sw_wdata", mem_wdata, 32'h11223344);

        // Three wait states, ack in the fourth cycle
        mem_ack = 1'b0;
        put(1'b1, 2'b01, 1'b0, 32'h300, 32'h0, 5'd9, 3'b010);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ws_stall%0d", i), {31'd0, StallM}, 32'd1);
            edge_w();
            chk($sformatf("ws_bubble%0d", i), {31'd0, RegWriteW}, 32'd0);
            @(negedge clk);
            #1;
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        #1;
        chk("ws_ack_stall", {31'd0, StallM}, 32'd0);
        edge_w();
        chk("ws_data", ReadDataW, 32'hCAFEF00D);
        chk("ws_regwrite", {31'd0, RegWriteW}, 32'd1);
        chk("ws_rd", {27'd0, RdW}, 32'd9);
        mem_ack = 1'b0;

        // Faults
        put(1'b1, 2'b01, 1'b0, 32'h102, 32'h0, 5'd4, 3'b010);
        chk("lw_mis_req", {31'd0, mem_req}, 32'd0);
        chk("lw_mis_stall", {31'd0, StallM}, 32'd0);
        edge_w();
        chk("lw_mis_fault", {31'd0, MemFaultW}, 32'd1);
        chk("lw_mis_regwrite", {31'd0, RegWriteW}, 32'd0);
        chk("lw_mis_alures", ALUResultW, 32'h102);
        put(1'b1, 2'b00, 1'b0, 32'h55, 32'h0, 5'd6, 3'b000);
        chk("alu_req", {31'd0, mem_req}, 32'd0);
        edge_w();
        chk("alu_fault_clear", {31'd0, MemFaultW}, 32'd0);
        chk("alu_regwrite", {31'd0, RegWriteW}, 32'd1);
        chk("alu_result", ALUResultW, 32'h55);
        put(1'b0, 2'b00, 1'b1, 32'h201, 32'hFFFF, 5'd0, 3'b001);
        chk("sh_mis_req", {31'd0, mem_req}, 32'd0);
        chk("sh_mis_be", {28'd0, mem_be}, 32'd0);
        edge_w();
        chk("sh_mis_fault", {31'd0, MemFaultW}, 32'd1);
        chk("sh_mis_regwrite", {31'd0, RegWriteW}, 32'd0);
        put(1'b1, 2'b01, 1'b0, 32'h100, 32'h0, 5'd4, 3'b011);
        chk("f3_ill_req", {31'd0, mem_req}, 32'd0);
        edge_w();
        chk("f3_ill_fault", {31'd0, MemFaultW}, 32'd1);
        chk("f3_ill_regwrite", {31'd0, RegWriteW}, 32'd0);

        // Timeout: no ack ever
        put(1'b1, 2'b01, 1'b0, 32'h400, 32'h0, 5'd8, 3'b010);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_stall%0d", i), {31'd0, StallM}, 32'd1);
            edge_w();
            chk($sformatf("to_bubble%0d", i), {31'd0, MemFaultW}, 32'd0);
            @(negedge clk);
            #1;
        end
        chk("to_release", {31'd0, StallM}, 32'd0);
        edge_w();
        chk("to_fault", {31'd0, MemFaultW}, 32'd1);
        chk("to_regwrite", {31'd0, RegWriteW}, 32'd0);
        chk("to_readdata", ReadDataW, 32'd0);
        mem_rdata = 32'h0BADF00D;
        mem_ack   = 1'b1;
        put(1'b1, 2'b01, 1'b0, 32'h100, 32'h0, 5'd2, 3'b010);
        chk("to_idle_stall", {31'd0, StallM}, 32'd0);
        edge_w();
        chk("to_idle_data", ReadDataW, 32'h0BADF00D);
        chk("to_idle_fault", {31'd0, MemFaultW}, 32'd0);

        // Reset during the second WAIT cycle
        mem_ack = 1'b0;
        put(1'b1, 2'b01, 1'b0, 32'h500, 32'h0, 5'd1, 3'b010);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rw_pre_stall", {31'd0, StallM}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_req", {31'd0, mem_req}, 32'd0);
        chk("rw_stall", {31'd0, StallM}, 32'd0);
        chk("rw_regwrite", {31'd0, RegWriteW}, 32'd0);
        chk("rw_fault", {31'd0, MemFaultW}, 32'd0);
        chk("rw_readdata", ReadDataW, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h600D600D;
        #1;
        chk("rw_after_stall", {31'd0, StallM}, 32'd0);
        edge_w();
        chk("rw_after_data", ReadDataW, 32'h600D600D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Pipelined RV32I Memory stage. It consumes the outputs of the E->M pipeline register and drives a handshaked data-memory port, stalling the pipeline while an access is outstanding.
- It formats byte, half and word stores and sign- or zero-extends loads.
- It contains the M->W pipeline register feeding writeback.
- Misaligned accesses, illegal width codes and bus timeouts are reported as a fault and never write the register file.

Parameters:
- DATA_WIDTH, 32, data and address width (fixed at 32 for RV32I).
- REG_FILE_ADDRESS_WIDTH, 5, destination register index width.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for mem_ack (minimum 1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- RegWriteM  in  1  register-file write enable.
- ResultSrcM  in  2  00 ALU result, 01 load data, 10 PC+4; a value of 01 marks a load.
- MemWriteM  in  1  marks a store.
- ALUResultM  in  DATA_WIDTH  effective address, or ALU result.
- WriteDataM  in  DATA_WIDTH  store data (rs2).
- RdM  in  REG_FILE_ADDRESS_WIDTH  destination register.
- PCPlus4M  in  DATA_WIDTH  PC+4.
- AddressingControlM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_req  out  1  access request.
- mem_we  out  1  1 = store.
- mem_addr  out  DATA_WIDTH  word-aligned address, {ALUResultM[31:2], 2'b00}.
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_be  out  4  byte enables (stores only; 0000 on loads).
- mem_rdata  in  DATA_WIDTH  read word, valid when mem_ack=1.
- mem_ack  in  1  access complete; may assert in the same cycle as mem_req.
- StallM  out  1  to hazard unit; upstream stages and the E->M register hold while high.
- RegWriteW  out  1  registered.
- ResultSrcW  out  2  registered.
- ALUResultW  out  DATA_WIDTH  registered.
- ReadDataW  out  DATA_WIDTH  registered, extended load data.
- RdW  out  REG_FILE_ADDRESS_WIDTH  registered.
- PCPlus4W  out  DATA_WIDTH  registered.
- MemFaultW  out  1  registered; one-cycle fault flag.

Behaviour:
- Definitions:
  - access = MemWriteM | (ResultSrcM==01).
  - off = ALUResultM[1:0].
  - illegal = funct3 not in {000, 001, 010, 100, 101}, or funct3 in {100, 101} with MemWriteM=1.
  - misaligned = H/HU with off[0]=1, or W with off!=00.
  - fault = access & (illegal | misaligned).
- Reset: all W outputs 0; state IDLE; timeout counter 0. mem_req and StallM are therefore 0.
- FSM states are IDLE and WAIT.
  - mem_req = access & ~fault & (IDLE | WAIT), driven combinationally.
  - IDLE -> WAIT when mem_req & ~mem_ack.
  - WAIT -> IDLE on mem_ack, or on timeout when the counter reaches TIMEOUT_CYCLES-1.
  - The counter clears on entry to WAIT and increments each WAIT cycle without ack.
- StallM = mem_req & ~mem_ack & ~timeout.
  - The M inputs are guaranteed stable while StallM=1.
  - A zero-wait ack produces no stall.
- Store formatting:
  - B: wdata = {4{WriteDataM[7:0]}}, be = 0001 << off.
  - H: wdata = {2{WriteDataM[15:0]}}, be = 0011 << off.
  - W: wdata = WriteDataM, be = 1111.
- Load extraction:
  - Select the byte or half of mem_rdata indexed by off.
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
- W register update, every cycle:
  - If StallM=1: load a bubble. RegWriteW=0, MemFaultW=0, all other W outputs 0.
  - Else if a fault or timeout occurred: RegWriteW=0, MemFaultW=1; the other fields still capture their M values, and ReadDataW=0.
  - Otherwise: capture all M fields. ReadDataW takes the extended load data when the access completes on ack, else 0.
- Non-access instructions (ALU ops, JAL) pass through with no mem_req and no stall.
- Reset asserted mid-WAIT returns the block to IDLE immediately. The request is dropped and no W write occurs.
- Back-to-back accesses: after the ack cycle the FSM is in IDLE. The next instruction's mem_req may assert in the following cycle.

Test Plan:
- Zero-wait loads:
  - LW at 0x100; memory returns 0xDEADBEEF with ack in the same cycle -> StallM never asserts.
  - Next cycle: ReadDataW = 0xDEADBEEF, RegWriteW = 1, mem_be = 0000 during the access.
- Load extension:
  - Memory word 0x80FF7F01; LB off=3 -> 0xFFFFFF80; LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF; LHU off=0 -> 0x00007F01.
- Store formatting:
  - SB of 0x123456AB at addr 0x203 -> mem_be = 1000, mem_wdata = 0xABABABAB, mem_addr = 0x200.
  - SH at 0x202 -> mem_be = 1100.
- Wait states:
  - ack delayed 3 cycles -> StallM high for exactly 3 cycles, W outputs show bubbles (RegWriteW = 0) in those cycles.
  - Data is captured on the ack cycle.
- Faults:
  - LW at 0x102 -> no mem_req, MemFaultW = 1, RegWriteW = 0 for one cycle.
  - SH at 0x201 -> same response.
  - funct3 = 011 -> same response.
- Timeout and reset:
  - TIMEOUT_CYCLES = 4, ack never asserts -> StallM is 1 for 4 cycles, then MemFaultW = 1 and the FSM returns to IDLE.
  - Assert rst in the 2nd WAIT cycle -> all W outputs 0 and mem_req = 0 immediately.
